// File: rtl/vae_pkg.sv
// Shared constants and helpers for the VAE reparameterisation datapath.
// Fixed-point format is signed Q4.11 on 16 bits.
package vae_pkg;

    localparam int                 FRAC_BITS = 11;
    localparam logic [15:0]        ONE       = 16'h0800;

    // Galois LFSR feedback mask (right-shifting form).
    localparam logic [15:0]        LFSR_MASK = 16'hB400;

    // Mean of four uniform nibbles is 30; subtracting it centres eps on zero.
    localparam logic signed [15:0] EPS_BIAS  = 16'sd30;

    // Gain mapping the nibble sum (std ~9.22) to roughly unit std in Q4.11.
    localparam int                 EPS_SCALE = 222;

    localparam logic [15:0]        SAT_MAX   = 16'h7FFF;
    localparam logic [15:0]        SAT_MIN   = 16'h8000;

    // Clamp a wide signed sum into the 16-bit signed output range.
    function automatic logic [15:0] sat16(input logic signed [33:0] v);
        logic [15:0] r;
        if (v > 34'sd32767) begin
            r = SAT_MAX;
        end else if (v < -34'sd32768) begin
            r = SAT_MIN;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vae_gauss_lfsr.sv
// Approximately-Gaussian noise source: a 16-bit Galois LFSR whose four
// nibbles are summed, debiased and scaled to produce a signed eps.
module vae_gauss_lfsr
    import vae_pkg::LFSR_MASK;
    import vae_pkg::EPS_BIAS;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          EPS_SCALE = 222
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_load,
    input  logic [15:0]        seed_in,
    input  logic               advance,
    output logic signed [15:0] eps
);

    // An all-zero state would lock the LFSR up, so zero seeds map to 1.
    localparam logic [15:0]        RESET_STATE = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic signed [15:0] SCALE_S     = 16'(EPS_SCALE);

    logic [15:0]        state_reg;
    logic [15:0]        state_next;
    logic [5:0]         nib_sum;
    logic signed [15:0] centred;

    // Next-state selection: a seed load overrides advancing.
    always_comb begin
        state_next = state_reg;
        if (seed_load) begin
            state_next = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
        end else if (advance) begin
            state_next = (state_reg >> 1) ^ (state_reg[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // eps is derived from the current state; range is +/-6660 at the default gain.
    always_comb begin
        nib_sum = {2'b00, state_reg[3:0]} + {2'b00, state_reg[7:4]}
                + {2'b00, state_reg[11:8]} + {2'b00, state_reg[15:12]};
        centred = $signed({10'd0, nib_sum}) - EPS_BIAS;
        eps     = centred * SCALE_S;
    end

endmodule

// File: rtl/vae_reparam_sampler.sv
// Reparameterisation stage: z = mu + sigma * eps, three-stage pipeline with
// valid/ready handshake, global stall and saturating signed Q4.11 output.
module vae_reparam_sampler
    import vae_pkg::sat16;
#(
    parameter int          BITSIZE   = 16,
    parameter int          FRAC_BITS = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          EPS_SCALE = 222
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_load,
    input  logic [BITSIZE-1:0] seed_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] mu_in,
    input  logic [BITSIZE-1:0] sigma_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] z_out
);

    logic               en;
    logic               accept;
    logic signed [15:0] eps;

    logic               v1_reg;
    logic signed [15:0] mu1_reg;
    logic signed [16:0] sigma1_reg;
    logic signed [15:0] eps1_reg;

    logic               v2_reg;
    logic signed [15:0] mu2_reg;
    logic signed [32:0] prod2_reg;

    logic               v3_reg;
    logic [15:0]        z_reg;

    logic signed [32:0] prod_full;
    logic signed [32:0] prod_next;
    logic signed [33:0] sum_full;

    vae_gauss_lfsr #(
        .LFSR_SEED (LFSR_SEED),
        .EPS_SCALE (EPS_SCALE)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .advance   (accept),
        .eps       (eps)
    );

    // Handshake: the whole pipeline moves only when the output slot is free.
    always_comb begin
        en       = !v3_reg || out_ready;
        in_ready = en && !seed_load;
        accept   = in_valid && in_ready;
    end

    // Multiply and rescale (floor division by 2^FRAC_BITS), then add with headroom.
    always_comb begin
        prod_full = {{16{sigma1_reg[16]}}, sigma1_reg} * {{17{eps1_reg[15]}}, eps1_reg};
        prod_next = prod_full >>> FRAC_BITS;
        sum_full  = {{18{mu2_reg[15]}}, mu2_reg} + {prod2_reg[32], prod2_reg};
    end

    // Three pipeline stages; everything holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_reg     <= 1'b0;
            mu1_reg    <= '0;
            sigma1_reg <= '0;
            eps1_reg   <= '0;
            v2_reg     <= 1'b0;
            mu2_reg    <= '0;
            prod2_reg  <= '0;
            v3_reg     <= 1'b0;
            z_reg      <= '0;
        end else if (en) begin
            v1_reg <= accept;
            if (accept) begin
                mu1_reg    <= $signed(mu_in[15:0]);
                sigma1_reg <= $signed({1'b0, sigma_in[15:0]});
                eps1_reg   <= eps;
            end
            v2_reg <= v1_reg;
            if (v1_reg) begin
                mu2_reg   <= mu1_reg;
                prod2_reg <= prod_next;
            end
            v3_reg <= v2_reg;
            if (v2_reg) begin
                z_reg <= sat16(sum_full);
            end
        end
    end

    assign out_valid = v3_reg;
    assign z_out     = BITSIZE'(z_reg);

endmodule

// File: tb/tb_vae_reparam_sampler.sv
// Scoreboard bench for vae_reparam_sampler: the driver pushes the expected z
// for each accepted input, and a monitor pops and compares on each output
// handshake.
module tb_vae_reparam_sampler;

    logic        clk;
    logic        reset;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mu_in;
    logic [15:0] sigma_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z_out;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_lfsr;

    vae_reparam_sampler dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mu_in     (mu_in),
        .sigma_in  (sigma_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    // Reference: z = sat(mu + floor(sigma * eps / 2048)), eps from LFSR nibbles.
    function automatic logic [15:0] model_z(input logic [15:0] mu, input logic [15:0] sg,
                                            input logic [15:0] st);
        int     nsum;
        longint eps;
        longint p;
        longint z;
        nsum = int'(st[3:0]) + int'(st[7:4]) + int'(st[11:8]) + int'(st[15:12]);
        eps  = longint'((nsum - 30) * 222);
        p    = (longint'(sg) * eps) >>> 11;
        z    = longint'($signed(mu)) + p;
        if (z > 32767) z = 32767;
        if (z < -32768) z = -32768;
        return 16'(z);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Offer one sample; on the accepting edge push its expected result.
    task automatic send(input logic [15:0] mu, input logic [15:0] sg,
                        input logic [15:0] exp_v, input bit use_exp);
        int waited;
        waited = 0;
        @(negedge clk);
        mu_in    = mu;
        sigma_in = sg;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(use_exp ? exp_v : model_z(mu, sg, m_lfsr));
        m_lfsr = lfsr_step(m_lfsr);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_seed(input logic [15:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed_in   = s;
        #1;
        check("seed_in_ready", {15'd0, in_ready}, 16'h0000);
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        m_lfsr    = (s == 16'h0000) ? 16'h0001 : s;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare each output handshake against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: z=0x%04h with empty scoreboard, required none", z_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                $display("out z=0x%04h exp=0x%04h", z_out, e);
                check("z_out", z_out, e);
            end
        end
    end

    initial begin
        logic [15:0] z_hold;
        reset     = 1'b0;
        seed_load = 1'b0;
        seed_in   = 16'h0000;
        in_valid  = 1'b0;
        mu_in     = 16'h0000;
        sigma_in  = 16'h0000;
        out_ready = 1'b1;
        m_lfsr    = 16'hACE1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("rst_z_out", z_out, 16'h0000);
        check("rst_in_ready", {15'd0, in_ready}, 16'h0001);
        reset = 1'b1;

        // Seed 0 -> state 1, eps = -6438; check latency
        load_seed(16'h0000);
        send(16'h0000, 16'h0800, 16'hE6DA, 1'b1);
        @(posedge clk); #1;
        check("latency_edge2", {15'd0, out_valid}, 16'h0000);
        @(posedge clk); #1;
        check("latency_edge3", {15'd0, out_valid}, 16'h0001);
        drain();

        // Back-to-back: state 1 then 0xB400 (nibble sum 15, eps = -3330)
        load_seed(16'h0000);
        send(16'h0000, 16'h0800, 16'hE6DA, 1'b1);
        send(16'h0000, 16'h0800, 16'hF2FE, 1'b1);
        drain();

        // Zero sigma returns mu for any LFSR state
        for (int i = 0; i < 4; i++) send(16'h0400, 16'h0000, 16'h0400, 1'b1);
        drain();

        // Positive saturation: eps = +6660, 7 * 6660 + 0x7000 overflows
        load_seed(16'hFFFF);
        send(16'h7000, 16'h3800, 16'h7FFF, 1'b1);
        drain();

        // Negative saturation: eps = -6438
        load_seed(16'h0000);
        send(16'h9000, 16'h3800, 16'h8000, 1'b1);
        drain();

        // Backpressure: four samples against a stalled sink
        load_seed(16'h0000);
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(16'h0000, 16'h0800, 16'hE6DA, 1'b1);
                send(16'h0000, 16'h0800, 16'hF2FE, 1'b1);
                send(16'h0100, 16'h1000, 16'h0000, 1'b0);
                send(16'hFF00, 16'h0400, 16'h0000, 1'b0);
            end
            begin
                repeat (8) @(negedge clk);
                #1;
                check("stall_in_ready", {15'd0, in_ready}, 16'h0000);
                check("stall_out_valid", {15'd0, out_valid}, 16'h0001);
                z_hold = z_out;
                repeat (3) @(negedge clk);
                #1;
                check("stall_z_hold", z_out, z_hold);
                check("stall_valid_hold", {15'd0, out_valid}, 16'h0001);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three samples in flight
        send(16'h0000, 16'h0800, 16'h0000, 1'b0);
        send(16'h0000, 16'h0800, 16'h0000, 1'b0);
        send(16'h0000, 16'h0800, 16'h0000, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("midrst_z_out", z_out, 16'h0000);
        exp_q.delete();
        @(negedge clk);
        reset  = 1'b1;
        m_lfsr = 16'hACE1;
        // 0xACE1 nibbles: 1+14+12+10 = 37 -> eps = 7*222 = 1554 = 0x0612
        send(16'h0000, 16'h0800, 16'h0612, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
